// File: rtl/axi4_lite_slv_reg_bank.sv
// rtl/axi4_lite_slv_reg_bank.sv - AXI4-Lite responder exposing NUM_REGS 32-bit control registers
// Optional macro AXI4_LITE_SLV_REG_BANK_RD_PIPE_EN adds a registered decode stage on the read path.
module axi4_lite_slv_reg_bank #(
   parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
   parameter int AXI4_LITE_DATA_BIT_WIDTH = 32,
   parameter int NUM_REGS                 = 8
) (
   input  logic                                         i_clk,
   input  logic                                         i_rst_n,
   input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]          i_awaddr,
   input  logic [2:0]                                   i_awprot,
   input  logic                                         i_awvalid,
   output logic                                         o_awready,
   input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]          i_wdata,
   input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0]        i_wstrb,
   input  logic                                         i_wvalid,
   output logic                                         o_wready,
   output logic [1:0]                                   o_bresp,
   output logic                                         o_bvalid,
   input  logic                                         i_bready,
   input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]          i_araddr,
   input  logic [2:0]                                   i_arprot,
   input  logic                                         i_arvalid,
   output logic                                         o_arready,
   output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]          o_rdata,
   output logic [1:0]                                   o_rresp,
   output logic                                         o_rvalid,
   input  logic                                         i_rready,
   output logic [NUM_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0] o_reg_vals,
   output logic [NUM_REGS-1:0]                          o_wr_pulse
);
   localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH;
   localparam int DW = AXI4_LITE_DATA_BIT_WIDTH;
   localparam logic [AW-1:0] ADDR_LIMIT = AW'(NUM_REGS * 4);

   if (DW != 32) begin : g_bad_data_width
      $error("axi4_lite_slv_reg_bank: only 32-bit data is supported");
   end
   if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
      $error("axi4_lite_slv_reg_bank: NUM_REGS must be 1..256");
   end

   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_DEC, R_SAMPLE, R_RESP} r_state_t;

   w_state_t                 w_state;
   r_state_t                 r_state;
   logic [NUM_REGS*DW-1:0]   reg_q;
   logic [AW-1:0]            aw_addr_q;
   logic [DW-1:0]            w_data_q;
   logic [DW/8-1:0]          w_strb_q;
   logic                     aw_hs;
   logic                     w_hs;
   logic                     ar_hs;
   logic [DW:0]              rd_sel;
   logic                     unused_prot;

   assign unused_prot = ^{i_awprot, i_arprot};
   assign aw_hs       = i_awvalid && o_awready;
   assign w_hs        = i_wvalid && o_wready;
   assign ar_hs       = i_arvalid && o_arready;
   assign o_reg_vals  = reg_q;

   // MSB flags an out-of-range address; data is zero in that case.
   function automatic logic [DW:0] lookup(input logic [AW-1:0] addr,
                                          input logic [NUM_REGS*DW-1:0] regs);
      logic [DW:0] res;
      res = {1'b1, {DW{1'b0}}};
      if (addr < ADDR_LIMIT) begin
         res = '0;
         for (int k = 0; k < NUM_REGS; k++) begin
            if (addr[9:2] == 8'(k)) res = {1'b0, regs[k*DW +: DW]};
         end
      end
      return res;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         w_state    <= W_IDLE;
         o_awready  <= 1'b1;
         o_wready   <= 1'b1;
         o_bvalid   <= 1'b0;
         o_bresp    <= 2'b00;
         o_wr_pulse <= '0;
         reg_q      <= '0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
      end else begin
         o_wr_pulse <= '0;
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_addr_q <= i_awaddr;
                  o_awready <= 1'b0;
               end
               if (w_hs) begin
                  w_data_q <= i_wdata;
                  w_strb_q <= i_wstrb;
                  o_wready <= 1'b0;
               end
               // A dropped ready means that channel was latched in an earlier cycle.
               if ((aw_hs || !o_awready) && (w_hs || !o_wready)) w_state <= W_COMMIT;
            end
            W_COMMIT: begin
               o_bvalid <= 1'b1;
               w_state  <= W_RESP;
               if (aw_addr_q < ADDR_LIMIT) begin
                  o_bresp <= 2'b00;
                  for (int k = 0; k < NUM_REGS; k++) begin
                     if (aw_addr_q[9:2] == 8'(k)) begin
                        o_wr_pulse[k] <= 1'b1;
                        for (int b = 0; b < DW/8; b++) begin
                           if (w_strb_q[b]) reg_q[k*DW + 8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                     end
                  end
               end else begin
                  o_bresp <= 2'b10;
               end
            end
            W_RESP: begin
               if (i_bready) begin
                  o_bvalid  <= 1'b0;
                  o_awready <= 1'b1;
                  o_wready  <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

`ifdef AXI4_LITE_SLV_REG_BANK_RD_PIPE_EN
   logic [DW:0] rd_pipe_q;
   assign rd_sel = rd_pipe_q;
`else
   logic [AW-1:0] ar_addr_q;
   assign rd_sel = lookup(ar_addr_q, reg_q);
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= R_IDLE;
         o_arready <= 1'b1;
         o_rvalid  <= 1'b0;
         o_rdata   <= '0;
         o_rresp   <= 2'b00;
`ifdef AXI4_LITE_SLV_REG_BANK_RD_PIPE_EN
         rd_pipe_q <= '0;
`else
         ar_addr_q <= '0;
`endif
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  o_arready <= 1'b0;
`ifdef AXI4_LITE_SLV_REG_BANK_RD_PIPE_EN
                  // Snapshot at the handshake edge so a later write cannot leak in.
                  rd_pipe_q <= lookup(i_araddr, reg_q);
                  r_state   <= R_DEC;
`else
                  ar_addr_q <= i_araddr;
                  r_state   <= R_SAMPLE;
`endif
               end
            end
            R_DEC: r_state <= R_SAMPLE;
            R_SAMPLE: begin
               o_rdata  <= rd_sel[DW-1:0];
               o_rresp  <= rd_sel[DW] ? 2'b10 : 2'b00;
               o_rvalid <= 1'b1;
               r_state  <= R_RESP;
            end
            R_RESP: begin
               if (i_rready) begin
                  o_rvalid  <= 1'b0;
                  o_arready <= 1'b1;
                  r_state   <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule
